// File: rtl/vga_timing_gen_if.sv
// Raster-side signal bundle for vga_timing_gen: pixel strobe in, sync/position/pulse outputs.
// master = the timing generator, slave = the consumer that supplies pix_en.
interface vga_timing_gen_if;
  logic       pix_en;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] vga_x;
  logic [8:0] vga_y;
  logic       line_start;
  logic       frame_start;

  modport master (
    input  pix_en,
    output hsync,
    output vsync,
    output video_on,
    output vga_x,
    output vga_y,
    output line_start,
    output frame_start
  );

  modport slave (
    output pix_en,
    input  hsync,
    input  vsync,
    input  video_on,
    input  vga_x,
    input  vga_y,
    input  line_start,
    input  frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parameterised VGA raster timing generator advancing one pixel per pix_en strobe.
// All outputs are registered and decoded from the next counter values, so they align with h/v.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  vga_timing_gen_if.master   vif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_video_on;
  logic [9:0] r_vga_x;
  logic [8:0] r_vga_y;
  logic       r_line_start;
  logic       r_frame_start;

  logic       w_h_wrap;
  logic [9:0] w_h_nxt;
  logic [9:0] w_v_nxt;
  logic       w_h_act;
  logic       w_v_act;
  logic       w_hsync_nxt;
  logic       w_vsync_nxt;

  always_comb begin
    w_h_wrap = (r_h_cnt == H_LAST);
    w_h_nxt  = w_h_wrap ? '0 : r_h_cnt + 10'd1;
    w_v_nxt  = r_v_cnt;
    if (w_h_wrap) begin
      w_v_nxt = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 10'd1;
    end
    w_h_act     = (w_h_nxt < H_ACT);
    w_v_act     = (w_v_nxt < V_ACT);
    w_hsync_nxt = ((w_h_nxt >= HS_BEG) && (w_h_nxt < HS_END)) ? SYNC_POL : ~SYNC_POL;
    w_vsync_nxt = ((w_v_nxt >= VS_BEG) && (w_v_nxt < VS_END)) ? SYNC_POL : ~SYNC_POL;
  end

  // Reset parks the raster on the last pixel so the first strobe lands on (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt       <= H_LAST;
      r_v_cnt       <= V_LAST;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_video_on    <= 1'b0;
      r_vga_x       <= '0;
      r_vga_y       <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (vif.pix_en) begin
      r_h_cnt       <= w_h_nxt;
      r_v_cnt       <= w_v_nxt;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_video_on    <= w_h_act && w_v_act;
      r_vga_x       <= w_h_act ? w_h_nxt : '0;
      r_vga_y       <= w_v_act ? w_v_nxt[8:0] : '0;
      r_line_start  <= (w_h_nxt == '0);
      r_frame_start <= (w_h_nxt == '0) && (w_v_nxt == '0);
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign vif.hsync       = r_hsync;
  assign vif.vsync       = r_vsync;
  assign vif.video_on    = r_video_on;
  assign vif.vga_x       = r_vga_x;
  assign vif.vga_y       = r_vga_y;
  assign vif.line_start  = r_line_start;
  assign vif.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance and a tiny SYNC_POL=1 instance,
// both checked every clock against a position-based model of the raster.
module tb_vga_timing_gen;

  logic clk;
  logic rst;

  vga_timing_gen_if vif_a();
  vga_timing_gen_if vif_b();

  vga_timing_gen u_a (
    .clk (clk),
    .rst (rst),
    .vif (vif_a)
  );

  vga_timing_gen #(
    .H_ACTIVE (8),
    .H_FP     (2),
    .H_SYNC   (2),
    .H_BP     (2),
    .V_ACTIVE (4),
    .V_FP     (1),
    .V_SYNC   (1),
    .V_BP     (1),
    .SYNC_POL (1'b1)
  ) u_b (
    .clk (clk),
    .rst (rst),
    .vif (vif_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: linear pixel index within the frame (v*H_TOTAL + h).
  localparam int TOT_A = 800 * 525;
  localparam int TOT_B = 14 * 7;
  int pos_a;
  int pos_b;
  bit adv;

  typedef struct {
    int         steps;
    logic       hs;
    logic       vs;
    logic       von;
    logic [9:0] x;
    logic [8:0] y;
    logic       ls;
    logic       fs;
  } vec_t;

  vec_t vecs[13];

  int von_cnt, hs_cnt, ls_last, ls_period, vs_cnt, fs_last, fs_period;

  function automatic logic [24:0] exp_out(input int ha, input int hfp, input int hsw, input int hbp,
                                          input int va, input int vfp, input int vsw, input int vbp,
                                          input logic pol, input int pos, input bit a);
    int ht, h, v;
    logic hs, vs, von, ls, fs;
    logic [9:0] x;
    logic [8:0] y;
    ht  = ha + hfp + hsw + hbp;
    h   = pos % ht;
    v   = pos / ht;
    hs  = (h >= ha + hfp && h < ha + hfp + hsw) ? pol : ~pol;
    vs  = (v >= va + vfp && v < va + vfp + vsw) ? pol : ~pol;
    von = (h < ha) && (v < va);
    x   = (h < ha) ? 10'(h) : 10'd0;
    y   = (v < va) ? 9'(v) : 9'd0;
    ls  = a && (h == 0);
    fs  = a && (pos == 0);
    return {hs, vs, von, x, y, ls, fs};
  endfunction

  function automatic logic [24:0] act_a();
    return {vif_a.hsync, vif_a.vsync, vif_a.video_on, vif_a.vga_x, vif_a.vga_y,
            vif_a.line_start, vif_a.frame_start};
  endfunction

  function automatic logic [24:0] act_b();
    return {vif_b.hsync, vif_b.vsync, vif_b.video_on, vif_b.vga_x, vif_b.vga_y,
            vif_b.line_start, vif_b.frame_start};
  endfunction

  task automatic chk(input string name, input logic [24:0] act, input logic [24:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h (hs,vs,von,x,y,ls,fs)", name, $time, act, expv);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, expv);
    end
  endtask

  task automatic check_models(input string name);
    chk({name, "_a"}, act_a(), exp_out(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, pos_a, adv));
    chk({name, "_b"}, act_b(), exp_out(8, 2, 2, 2, 4, 1, 1, 1, 1'b1, pos_b, adv));
  endtask

  task automatic step(input logic en);
    vif_a.pix_en = en;
    vif_b.pix_en = en;
    @(posedge clk);
    #1;
    adv = en;
    if (en) begin
      pos_a = (pos_a + 1) % TOT_A;
      pos_b = (pos_b + 1) % TOT_B;
    end
    check_models("step");
  endtask

  // Raises rst between edges to observe the asynchronous clear, holds it across an edge with pix_en=1.
  task automatic do_reset();
    #1;
    rst = 1'b1;
    pos_a = TOT_A - 1;
    pos_b = TOT_B - 1;
    adv   = 1'b0;
    #1;
    check_models("rst_async");
    vif_a.pix_en = 1'b1;
    vif_b.pix_en = 1'b1;
    @(posedge clk);
    #1;
    check_models("rst_hold");
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    vif_a.pix_en = 1'b0;
    vif_b.pix_en = 1'b0;
    pos_a = TOT_A - 1;
    pos_b = TOT_B - 1;
    adv = 1'b0;

    // Small-config expectations: H_TOTAL=14, V_TOTAL=7, active-high syncs at h=10..11 and v=5.
    vecs[0]  = '{0,   1'b0, 1'b0, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0};
    vecs[1]  = '{1,   1'b0, 1'b0, 1'b1, 10'd0, 9'd0, 1'b1, 1'b1};
    vecs[2]  = '{2,   1'b0, 1'b0, 1'b1, 10'd1, 9'd0, 1'b0, 1'b0};
    vecs[3]  = '{9,   1'b0, 1'b0, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0};
    vecs[4]  = '{11,  1'b1, 1'b0, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0};
    vecs[5]  = '{12,  1'b1, 1'b0, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0};
    vecs[6]  = '{13,  1'b0, 1'b0, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0};
    vecs[7]  = '{15,  1'b0, 1'b0, 1'b1, 10'd0, 9'd1, 1'b1, 1'b0};
    vecs[8]  = '{46,  1'b0, 1'b0, 1'b1, 10'd3, 9'd3, 1'b0, 1'b0};
    vecs[9]  = '{71,  1'b0, 1'b1, 1'b0, 10'd0, 9'd0, 1'b1, 1'b0};
    vecs[10] = '{84,  1'b0, 1'b1, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0};
    vecs[11] = '{85,  1'b0, 1'b0, 1'b0, 10'd0, 9'd0, 1'b1, 1'b0};
    vecs[12] = '{99,  1'b0, 1'b0, 1'b1, 10'd0, 9'd0, 1'b1, 1'b1};

    @(posedge clk);
    #1;
    for (int i = 0; i < 13; i++) begin
      do_reset();
      for (int k = 0; k < vecs[i].steps; k++) step(1'b1);
      chk($sformatf("vec%0d", i), act_b(),
          {vecs[i].hs, vecs[i].vs, vecs[i].von, vecs[i].x, vecs[i].y, vecs[i].ls, vecs[i].fs});
    end

    // Default line timing with pix_en tied high.
    do_reset();
    von_cnt = 0; hs_cnt = 0; ls_last = -1; ls_period = 0;
    for (int c = 0; c < 1602; c++) begin
      step(1'b1);
      if (c < 800) begin
        if (vif_a.video_on) von_cnt++;
        if (!vif_a.hsync) hs_cnt++;
      end
      if (vif_a.line_start) begin
        if (ls_last >= 0) ls_period = c - ls_last;
        ls_last = c;
      end
    end
    chk_int("line_video_on_clks", von_cnt, 640);
    chk_int("line_hsync_clks", hs_cnt, 96);
    chk_int("line_start_period", ls_period, 800);

    // Small config, pix_en on every 4th clock.
    do_reset();
    vs_cnt = 0; fs_last = -1; fs_period = 0;
    for (int c = 0; c < 800; c++) begin
      step((c % 4) == 0);
      if (c < 392 && vif_b.vsync) vs_cnt++;
      if (vif_b.frame_start) begin
        if (fs_last >= 0) fs_period = c - fs_last;
        fs_last = c;
      end
    end
    chk_int("div4_vsync_clks", vs_cnt, 56);
    chk_int("div4_frame_period", fs_period, 392);

    // Reset landing inside both sync pulses of the small config (h=11, v=5).
    do_reset();
    for (int k = 0; k < 82; k++) step(1'b1);
    chk_int("midsync_hsync", int'(vif_b.hsync), 1);
    chk_int("midsync_vsync", int'(vif_b.vsync), 1);
    do_reset();
    step(1'b1);
    chk_int("post_rst_frame_start", int'(vif_b.frame_start), 1);

    // Randomised strobes with occasional mid-frame resets.
    do_reset();
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 799) == 0) do_reset();
      else step(($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
